// File: rtl/axi_lsu_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_lsu_master : single-outstanding CPU load/store to AXI4 master bridge   |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module axi_lsu_master #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  // CPU request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  // CPU completion side
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // AXI4 write address
  output logic        io_master_awvalid,
  input  logic        io_master_awready,
  output logic [31:0] io_master_awaddr,
  output logic [3:0]  io_master_awid,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  // AXI4 write data
  output logic        io_master_wvalid,
  input  logic        io_master_wready,
  output logic [31:0] io_master_wdata,
  output logic [3:0]  io_master_wstrb,
  output logic        io_master_wlast,
  // AXI4 write response
  input  logic        io_master_bvalid,
  output logic        io_master_bready,
  input  logic [1:0]  io_master_bresp,
  input  logic [3:0]  io_master_bid,
  // AXI4 read address
  output logic        io_master_arvalid,
  input  logic        io_master_arready,
  output logic [31:0] io_master_araddr,
  output logic [3:0]  io_master_arid,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  // AXI4 read data
  input  logic        io_master_rvalid,
  output logic        io_master_rready,
  input  logic [1:0]  io_master_rresp,
  input  logic [31:0] io_master_rdata,
  input  logic        io_master_rlast,
  input  logic [3:0]  io_master_rid
);

  localparam logic [7:0] c_LEN_SINGLE = 8'd0;
  localparam logic [1:0] c_BURST_INCR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [2:0]  r_size;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;

  logic        r_req_ready;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_arvalid;
  logic        r_bready;
  logic        r_rready;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;

  logic        w_rd_err;
  logic        w_wr_err;
  logic        w_unused_rlast;

  // Single-beat reads complete on the first data beat, so rlast carries no information.
  assign w_unused_rlast = io_master_rlast;

  assign w_rd_err = (io_master_rresp != 2'b00) || (io_master_rid != AXI_ID);
  assign w_wr_err = (io_master_bresp != 2'b00) || (io_master_bid != AXI_ID);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_addr       <= 32'd0;
      r_size       <= 3'd0;
      r_wdata      <= 32'd0;
      r_wstrb      <= 4'd0;
      r_req_ready  <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_bready     <= 1'b0;
      r_rready     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_addr      <= req_addr;
            r_size      <= req_size;
            r_wdata     <= req_wdata;
            r_wstrb     <= req_wstrb;
            r_req_ready <= 1'b0;
            if (req_wen) begin
              r_state   <= S_WR_REQ;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_state   <= S_RD_ADDR;
              r_arvalid <= 1'b1;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end

        S_RD_ADDR: begin
          if (io_master_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (io_master_rvalid && r_rready) begin
            r_rready     <= 1'b0;
            r_resp_rdata <= io_master_rdata;
            r_resp_err   <= w_rd_err;
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end
        end

        S_WR_REQ: begin
          if (r_awvalid && io_master_awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && io_master_wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // Both channels are tracked by registered flags, so exit follows the later handshake.
          if (r_aw_done && r_w_done) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end

        S_WR_RESP: begin
          if (io_master_bvalid && r_bready) begin
            r_bready     <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= w_wr_err;
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end
        end

        S_DONE: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready         = r_req_ready;
  assign resp_valid        = r_resp_valid;
  assign resp_rdata        = r_resp_rdata;
  assign resp_err          = r_resp_err;

  assign io_master_awvalid = r_awvalid;
  assign io_master_awaddr  = r_addr;
  assign io_master_awid    = AXI_ID;
  assign io_master_awlen   = c_LEN_SINGLE;
  assign io_master_awsize  = r_size;
  assign io_master_awburst = c_BURST_INCR;

  assign io_master_wvalid  = r_wvalid;
  assign io_master_wdata   = r_wdata;
  assign io_master_wstrb   = r_wstrb;
  assign io_master_wlast   = r_wvalid;

  assign io_master_bready  = r_bready;

  assign io_master_arvalid = r_arvalid;
  assign io_master_araddr  = r_addr;
  assign io_master_arid    = AXI_ID;
  assign io_master_arlen   = c_LEN_SINGLE;
  assign io_master_arsize  = r_size;
  assign io_master_arburst = c_BURST_INCR;

  assign io_master_rready  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axi_lsu_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_lsu_master : self-checking bench with a delay-programmable AXI slave |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_axi_lsu_master;

  localparam logic [3:0] TB_AXI_ID = 4'h0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_wen = 0, resp_ready = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [2:0]  req_size = 0;
  logic [3:0]  req_wstrb = 0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [31:0] awaddr, araddr, wdata;
  logic [3:0]  awid, arid, wstrb;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic        awready = 0, wready = 0, arready = 0, bvalid = 0, rvalid = 0, rlast = 0;
  logic [1:0]  bresp = 0, rresp = 0;
  logic [3:0]  bid = 0, rid = 0;
  logic [31:0] rdata = 0;

  axi_lsu_master #(.AXI_ID(TB_AXI_ID)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize), .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bvalid(bvalid), .io_master_bready(bready), .io_master_bresp(bresp), .io_master_bid(bid),
    .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize), .io_master_arburst(arburst),
    .io_master_rvalid(rvalid), .io_master_rready(rready), .io_master_rresp(rresp),
    .io_master_rdata(rdata), .io_master_rlast(rlast), .io_master_rid(rid)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave behaviour knobs
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [1:0]  rresp_cfg = 0, bresp_cfg = 0;
  logic [3:0]  rid_cfg = 0, bid_cfg = 0;
  logic        rlast_cfg = 1, force_en = 0;
  logic [31:0] force_data = 0;

  // Payload captured by the slave at each address/data handshake
  logic [31:0] cap_araddr = 0, cap_awaddr = 0, cap_wdata = 0;
  logic [7:0]  cap_arlen = 0, cap_awlen = 0;
  logic [2:0]  cap_arsize = 0, cap_awsize = 0;
  logic [1:0]  cap_arburst = 0, cap_awburst = 0;
  logic [3:0]  cap_arid = 0, cap_awid = 0, cap_wstrb = 0;

  // Transaction monitor counters
  int mon_aw, mon_w, mon_early, mon_wlast_bad;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // Reactive slave: decide handshakes at negedge, react 1ns after the posedge
  initial begin : slave
    logic hs_ar, hs_aw, hs_w, hs_r, hs_b;
    logic ar_armed, aw_armed, w_armed, r_pend, b_pend, got_aw, got_w;
    logic prev_ar, prev_aw, prev_w;
    logic [38:0] pay_ar, pay_aw;
    logic [35:0] pay_w;
    logic [31:0] r_addr;
    int ar_cnt, aw_cnt, w_cnt, r_cnt, b_cnt;
    ar_armed = 0; aw_armed = 0; w_armed = 0; r_pend = 0; b_pend = 0; got_aw = 0; got_w = 0;
    prev_ar = 0; prev_aw = 0; prev_w = 0; pay_ar = 0; pay_aw = 0; pay_w = 0; r_addr = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0; b_cnt = 0;
    forever begin
      @(negedge clk);
      hs_ar = arvalid && arready;
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      hs_r  = rvalid && rready;
      hs_b  = bvalid && bready;
      if (prev_ar && arvalid) begin
        checks++;
        if ({araddr, arsize, arid} !== pay_ar) begin
          failures++; $display("FAIL ar_stable: got %h required %h", {araddr, arsize, arid}, pay_ar);
        end
      end
      if (prev_aw && awvalid) begin
        checks++;
        if ({awaddr, awsize, awid} !== pay_aw) begin
          failures++; $display("FAIL aw_stable: got %h required %h", {awaddr, awsize, awid}, pay_aw);
        end
      end
      if (prev_w && wvalid) begin
        checks++;
        if ({wdata, wstrb} !== pay_w) begin
          failures++; $display("FAIL w_stable: got %h required %h", {wdata, wstrb}, pay_w);
        end
      end
      prev_ar = arvalid && !arready; pay_ar = {araddr, arsize, arid};
      prev_aw = awvalid && !awready; pay_aw = {awaddr, awsize, awid};
      prev_w  = wvalid && !wready;   pay_w  = {wdata, wstrb};
      if (hs_ar) begin
        cap_araddr = araddr; cap_arlen = arlen; cap_arsize = arsize; cap_arburst = arburst; cap_arid = arid;
      end
      if (hs_aw) begin
        cap_awaddr = awaddr; cap_awlen = awlen; cap_awsize = awsize; cap_awburst = awburst; cap_awid = awid;
      end
      if (hs_w) begin
        cap_wdata = wdata; cap_wstrb = wstrb;
      end
      @(posedge clk);
      #1;
      if (!reset_n) begin
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        ar_armed = 0; aw_armed = 0; w_armed = 0; r_pend = 0; b_pend = 0; got_aw = 0; got_w = 0;
        prev_ar = 0; prev_aw = 0; prev_w = 0;
      end else begin
        if (hs_ar) begin
          arready = 0; ar_armed = 0; r_pend = 1; r_cnt = r_dly; rvalid = 0; r_addr = cap_araddr;
        end
        if (arvalid && !ar_armed && !arready) begin ar_armed = 1; ar_cnt = ar_dly; end
        if (ar_armed && !arready) begin
          if (ar_cnt == 0) arready = 1; else ar_cnt--;
        end
        if (hs_r) begin r_pend = 0; rvalid = 0; end
        if (r_pend && !rvalid) begin
          if (r_cnt == 0) begin
            rvalid = 1; rdata = force_en ? force_data : mem_word(r_addr);
            rresp = rresp_cfg; rid = rid_cfg; rlast = rlast_cfg;
          end else r_cnt--;
        end
        if (hs_aw) begin awready = 0; aw_armed = 0; got_aw = 1; end
        if (hs_w)  begin wready = 0;  w_armed = 0;  got_w = 1;  end
        if (awvalid && !aw_armed && !awready) begin aw_armed = 1; aw_cnt = aw_dly; end
        if (wvalid && !w_armed && !wready) begin w_armed = 1; w_cnt = w_dly; end
        if (aw_armed && !awready) begin
          if (aw_cnt == 0) awready = 1; else aw_cnt--;
        end
        if (w_armed && !wready) begin
          if (w_cnt == 0) wready = 1; else w_cnt--;
        end
        if (hs_b) begin b_pend = 0; bvalid = 0; end
        if (got_aw && got_w && !b_pend) begin b_pend = 1; b_cnt = b_dly; got_aw = 0; got_w = 0; end
        if (b_pend && !bvalid) begin
          if (b_cnt == 0) begin bvalid = 1; bresp = bresp_cfg; bid = bid_cfg; end
          else b_cnt--;
        end
      end
    end
  end

  // One complete request/response exchange; holds resp_ready low for 'hold' cycles first
  task automatic txn(input logic wen, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wd, input logic [3:0] ws, input int hold,
                     output logic [31:0] rd, output logic er, output int lat);
    int t0, k, bad;
    mon_aw = 0; mon_w = 0; mon_early = 0; mon_wlast_bad = 0; bad = 0;
    rd = 0; er = 0; lat = -1;
    @(negedge clk);
    req_valid = 1; req_wen = wen; req_addr = addr; req_size = size; req_wdata = wd; req_wstrb = ws;
    k = 0;
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    checks++;
    if (!req_ready) begin
      failures++; $display("FAIL accept_timeout: req_ready=%b required 1", req_ready);
      req_valid = 0;
      return;
    end
    t0 = cyc;
    @(negedge clk);
    req_valid = 0; req_wen = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
    k = 0;
    while (!resp_valid && k < 400) begin
      if (awvalid) mon_aw++;
      if (wvalid) mon_w++;
      if (wvalid && !wlast) mon_wlast_bad++;
      if (bready && (awvalid || wvalid)) mon_early++;
      if (req_ready) bad++;
      @(negedge clk); k++;
    end
    checks++;
    if (!resp_valid) begin
      failures++; $display("FAIL resp_timeout: resp_valid=%b required 1", resp_valid);
      return;
    end
    lat = cyc - t0; rd = resp_rdata; er = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0) bad++;
    end
    if (req_ready !== 1'b0) bad++;
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL txn_protocol: %0d violations required 0", bad);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, resp_valid, resp_err, req_ready} !== 8'd0) begin
      failures++; $display("FAIL reset_ctrl: got %b required 00000000",
                           {awvalid, wvalid, arvalid, bready, rready, resp_valid, resp_err, req_ready});
    end
    checks++;
    if ({resp_rdata, araddr, wdata, wstrb} !== 68'd0) begin
      failures++; $display("FAIL reset_payload: got %h required 0", {resp_rdata, araddr, wdata, wstrb});
    end
    reset_n = 1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      failures++; $display("FAIL ready_before_edge: got %b required 0", req_ready);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL ready_first_edge: got %b required 1", req_ready);
    end
  endtask

  task automatic test_read_basic();
    logic [31:0] rd; logic er; int lat;
    ar_dly = 0; r_dly = 0; force_en = 1; force_data = 32'hDEADBEEF;
    txn(1'b0, 32'h80000004, 3'd2, 32'h0, 4'h0, 0, rd, er, lat);
    force_en = 0;
    checks++;
    if (lat != 3) begin failures++; $display("FAIL rd_latency: got %0d required 3", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      failures++; $display("FAIL rd_data: got %h err %b required deadbeef err 0", rd, er);
    end
    checks++;
    if ({cap_araddr, cap_arlen, cap_arburst, cap_arsize, cap_arid} !== {32'h80000004, 8'd0, 2'b01, 3'd2, TB_AXI_ID}) begin
      failures++; $display("FAIL ar_payload: got %h %h %b %0d %h required 80000004 00 01 2 %h",
                           cap_araddr, cap_arlen, cap_arburst, cap_arsize, cap_arid, TB_AXI_ID);
    end
  endtask

  task automatic test_write_delayed();
    logic [31:0] rd; logic er; int lat;
    aw_dly = 2; w_dly = 0; b_dly = 0;
    txn(1'b1, 32'h00001000, 3'd2, 32'h12345678, 4'hF, 0, rd, er, lat);
    checks++;
    if (mon_aw != 3 || mon_w != 1) begin
      failures++; $display("FAIL wr_valid_cycles: aw %0d w %0d required aw 3 w 1", mon_aw, mon_w);
    end
    checks++;
    if (mon_early != 0 || mon_wlast_bad != 0) begin
      failures++; $display("FAIL wr_order: early_bready %0d wlast_bad %0d required 0 0", mon_early, mon_wlast_bad);
    end
    checks++;
    if ({cap_awaddr, cap_awlen, cap_awburst, cap_wdata, cap_wstrb} !== {32'h00001000, 8'd0, 2'b01, 32'h12345678, 4'hF}) begin
      failures++; $display("FAIL wr_payload: got %h %h %b %h %h required 00001000 00 01 12345678 f",
                           cap_awaddr, cap_awlen, cap_awburst, cap_wdata, cap_wstrb);
    end
    checks++;
    if (rd !== 32'd0 || er !== 1'b0 || lat != 6) begin
      failures++; $display("FAIL wr_resp: got rdata %h err %b lat %0d required 0 0 6", rd, er, lat);
    end
    aw_dly = 0;
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    for (int c = 0; c < 5; c++) begin
      rresp_cfg = (c == 0) ? 2'b10 : 2'b00;
      rid_cfg   = (c == 1) ? 4'h5 : TB_AXI_ID;
      bid_cfg   = (c == 2) ? 4'h3 : TB_AXI_ID;
      bresp_cfg = (c == 3) ? 2'b11 : 2'b00;
      txn((c == 2 || c == 3 || c == 4), 32'h100 + 32'(c * 4), 3'd2, 32'hA5A5_0000 + 32'(c), 4'h3, 0, rd, er, lat);
      checks++;
      if (er !== (c != 4)) begin
        failures++; $display("FAIL err_case%0d: got %b required %b", c, er, (c != 4));
      end
    end
    rresp_cfg = 0; rid_cfg = TB_AXI_ID; bid_cfg = TB_AXI_ID; bresp_cfg = 0;
  endtask

  task automatic test_random();
    logic [31:0] rd, a, d; logic [3:0] s; logic [2:0] sz; logic er; int lat, m, expl;
    rlast_cfg = 0;
    for (int n = 0; n < 100; n++) begin
      ar_dly = $urandom_range(0, 20); r_dly = $urandom_range(0, 20);
      a = $urandom; sz = 3'($urandom_range(0, 2));
      txn(1'b0, a, sz, 32'h0, 4'h0, $urandom_range(0, 2), rd, er, lat);
      checks++;
      if (rd !== mem_word(a) || er !== 1'b0 || cap_araddr !== a || cap_arsize !== sz) begin
        failures++; $display("FAIL rand_read%0d: got %h err %b addr %h required %h 0 %h", n, rd, er, cap_araddr, mem_word(a), a);
      end
      checks++;
      if (lat != 3 + ar_dly + r_dly) begin
        failures++; $display("FAIL rand_read_lat%0d: got %0d required %0d", n, lat, 3 + ar_dly + r_dly);
      end
    end
    rlast_cfg = 1;
    for (int n = 0; n < 30; n++) begin
      aw_dly = $urandom_range(0, 6); w_dly = $urandom_range(0, 6); b_dly = $urandom_range(0, 6);
      a = $urandom; d = $urandom; s = 4'($urandom); sz = 3'($urandom_range(0, 2));
      txn(1'b1, a, sz, d, s, 0, rd, er, lat);
      m = (aw_dly > w_dly) ? aw_dly : w_dly;
      expl = 4 + m + ((b_dly > 1) ? b_dly - 1 : 0);
      checks++;
      if (cap_awaddr !== a || cap_awsize !== sz || cap_wdata !== d || cap_wstrb !== s || rd !== 32'd0 || er !== 1'b0) begin
        failures++; $display("FAIL rand_write%0d: got %h %0d %h %h rdata %h err %b required %h %0d %h %h 0 0",
                             n, cap_awaddr, cap_awsize, cap_wdata, cap_wstrb, rd, er, a, sz, d, s);
      end
      checks++;
      if (lat != expl || mon_early != 0) begin
        failures++; $display("FAIL rand_write_lat%0d: got %0d early %0d required %0d 0", n, lat, mon_early, expl);
      end
    end
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
  endtask

  task automatic test_resp_stall();
    logic [31:0] rd; logic er; int lat;
    txn(1'b0, 32'h0000_0040, 3'd2, 32'h0, 4'h0, 5, rd, er, lat);
    checks++;
    if (rd !== mem_word(32'h40) || er !== 1'b0) begin
      failures++; $display("FAIL stall_data: got %h err %b required %h 0", rd, er, mem_word(32'h40));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat, k, seen;
    r_dly = 10;
    @(negedge clk);
    req_valid = 1; req_wen = 0; req_addr = 32'h0000_2000; req_size = 3'd2;
    k = 0;
    while (!req_ready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    req_valid = 0;
    k = 0;
    while (!rready && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (!rready) begin failures++; $display("FAIL mid_reach_rd_data: rready=%b required 1", rready); end
    #2 reset_n = 0;
    #1;
    checks++;
    if ({awvalid, wvalid, arvalid, bready, rready, resp_valid, req_ready, resp_rdata} !== 39'd0) begin
      failures++; $display("FAIL mid_reset_async: got %h required 0",
                           {awvalid, wvalid, arvalid, bready, rready, resp_valid, req_ready, resp_rdata});
    end
    @(negedge clk);
    reset_n = 1;
    r_dly = 0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid || arvalid || rready) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL mid_no_completion: %0d active cycles required 0", seen); end
    txn(1'b0, 32'h0000_3000, 3'd2, 32'h0, 4'h0, 0, rd, er, lat);
    checks++;
    if (rd !== mem_word(32'h3000) || er !== 1'b0 || lat != 3) begin
      failures++; $display("FAIL mid_recover: got %h err %b lat %0d required %h 0 3", rd, er, lat, mem_word(32'h3000));
    end
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_basic();
    test_write_delayed();
    test_errors();
    test_resp_stall();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
